gvram_bus_master: RTL and testbench
===================================

# gvram_bus_master

Host-side initiator for the GVRAM board bus: drives the MZ-side I/O port writes (ports F4–F7, via `nF47`/`nIWR`/`IOAD`/`IODB`) and the GVRAM memory cycles (`nCSED`/`nRD`/`nWD`/address/data). It is the counterpart of the board's responder logic: it turns a simple valid/ready command stream into strobes that meet the board's hold-off rules. It confines memory cycles to blanking windows and aborts and retries any cycle whose window closes early. It serves bring-up benches, self-test, and CPU-less pattern loaders.

## Interface
- `SETUP_CLKS`, 2: clocks the address/data are stable before strobes fall (≥1).
- `STROBE_CLKS`, 6: clocks the strobes stay low (≥5; the board qualifies strobes only after 4 clocks low).
- `HOLD_CLKS`, 2: clocks the address/data are held after strobes rise (≥1).
- `CLK` input 1: 50 MHz system clock.
- `nRST` input 1: asynchronous, active-low reset.
- `cmd_valid` input 1: command offered.
- `cmd_ready` output 1: block idle and accepting.
- `cmd_type` input 2: 0 = I/O write, 1 = memory write, 2 = memory read, 3 = reserved (accepted, no bus activity).
- `cmd_addr` input 14: GVRAM address; bits [1:0] select the port for I/O writes (F4..F7).
- `cmd_data` input 8: write data; bits [3:0] are used for I/O writes.
- `rsp_valid` output 1: one-cycle pulse with read data.
- `rsp_data` output 8: read data; holds its value until the next read.
- `abort_cnt` output 8: saturating count of window-closed aborts.
- `nHBLANK`, `nVBLANK` input 1 each: blanking from the host. The window is open when `~(nHBLANK & nVBLANK)`.
- `nCSED`, `nF47`, `nIWR`, `nRD`, `nWD` output 1 each: active-low strobes.
- `IOAD` output 2 and `IODB` output 4: I/O port address and data.
- `AD` output 14: memory address.
- `DB_O` output 8, `DB_OE` output 1, `DB_I` input 8: split data bus. The pad tristate lives outside this block.

## Operation
- Reset values:
  - All strobes 1.
  - `cmd_ready` 1, `rsp_valid` 0.
  - `rsp_data`, `AD`, `IOAD`, `IODB`, `DB_O` 0.
  - `DB_OE` 0, `abort_cnt` 0.
  - State IDLE.
- FSM states: IDLE, WAITWIN, SETUP, STROBE, HOLD.
- IDLE: `cmd_ready`=1. On `cmd_valid`, the command is latched and `cmd_ready` drops on the next cycle.
  - I/O write goes to SETUP unconditionally; blanking is ignored.
  - Memory command goes to SETUP if the window is open, else WAITWIN.
  - Type 3 returns to IDLE (one-cycle busy).
- WAITWIN: strobes high, address driven. Moves to SETUP on the first cycle the window is open.
- SETUP: `AD`/`IOAD`/`IODB` driven. `DB_OE`=1 and `DB_O` driven for memory writes. After `SETUP_CLKS` cycles, goes to STROBE.
- STROBE: `STROBE_CLKS` cycles.
  - I/O write: `nF47`=0, `nIWR`=0.
  - Memory write: `nCSED`=0, `nWD`=0.
  - Memory read: `nCSED`=0, `nRD`=0. `DB_I` is sampled into `rsp_data` on the last STROBE cycle.
- Abort: during a memory STROBE, a window-closed cycle (`nHBLANK`=1 and `nVBLANK`=1) sampled at the clock edge causes:
  - all strobes high at the next edge;
  - `abort_cnt` incremented (saturates at 255);
  - transition to WAITWIN;
  - the whole SETUP+STROBE sequence is replayed.
  - I/O writes never abort.
- HOLD: strobes high, address/data still driven for `HOLD_CLKS` cycles, then IDLE.
  - `DB_OE` falls on exit from HOLD.
  - For reads, `rsp_valid` pulses for one cycle on HOLD entry.
- Strobes are registered outputs with no combinational paths from inputs, so they are glitch-free.
- One 4-bit down-counter serves SETUP, STROBE, and HOLD. It is loaded with N−1 on state entry and the state ends at 0.

## Timing
- Accept edge = cycle 0. SETUP occupies cycles 1..S, strobes are low during S+1..S+T, HOLD occupies S+T+1..S+T+H, and `cmd_ready`=1 at cycle S+T+H+1.
- Defaults: strobes low during cycles 3–8, `rsp_valid` at cycle 9, ready again at cycle 11 (11-cycle throughput).
- WAITWIN adds its cycles before SETUP. An abort restarts the count from WAITWIN.
- A window close in the very last STROBE cycle still aborts; the read data from that cycle is discarded.
- Asynchronous `nRST` mid-cycle: strobes deassert immediately and any pending response is dropped.
- `nHBLANK`/`nVBLANK` are double-flopped before use, adding 2 cycles of window latency.

## Structure
- Shared package `gvram_pkg`:
  - command-type encodings (`CMD_IOW`, `CMD_MWR`, `CMD_MRD`, `CMD_NOP`);
  - port codes F4..F7 = 2'b00..2'b11;
  - minimum `STROBE_CLKS` constant 5.
- One natural sub-module: `blank_sync` (2-flop synchronizer plus window-open decode).
- Elaboration check: `STROBE_CLKS` ≥ 5 and each of the three parameters ≤ 15.

## Test plan
- I/O write, `cmd_addr`=14'h0002, `cmd_data`=8'h0B, window closed → `nF47`/`nIWR` low for cycles 3–8, `IOAD`=2'b10, `IODB`=4'hB, `cmd_ready` high at cycle 11.
- Memory write 14'h1234←8'hA5 with `nVBLANK`=0 → `nCSED`/`nWD` low for 6 cycles, `DB_OE`=1 during cycles 1–10, `AD`=14'h1234.
- Memory read 14'h0FFF with window open, `DB_I`=8'h5A → `rsp_valid` at cycle 9, `rsp_data`=8'h5A.
- Memory write issued with the window closed for 20 cycles → WAITWIN; strobes stay high until 2 cycles after the window opens.
- Window closes at STROBE cycle 3 → strobes high next edge, `abort_cnt`=1, full replay on reopen, single `rsp_valid`.
- `nRST` asserted at STROBE cycle 2 → all strobes 1 and `cmd_ready`=1 immediately, no `rsp_valid`; 300 forced aborts → `abort_cnt` stays at 255.

Source files
------------

// File: rtl/gvram_pkg.sv
// Shared definitions for the GVRAM bus initiator: command encodings, port codes,
// FSM state codes and strobe timing limits.
package gvram_pkg;

  typedef enum logic [1:0] {
    CMD_IOW = 2'd0,
    CMD_MWR = 2'd1,
    CMD_MRD = 2'd2,
    CMD_NOP = 2'd3
  } cmd_type_e;

  // I/O port select carried on IOAD (board ports F4..F7)
  typedef enum logic [1:0] {
    PORT_F4 = 2'b00,
    PORT_F5 = 2'b01,
    PORT_F6 = 2'b10,
    PORT_F7 = 2'b11
  } port_e;

  // The board only qualifies a strobe after 4 clocks low, so 5 is the floor.
  localparam int MIN_STROBE_CLKS = 5;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WAITWIN = 3'd1;
  localparam logic [2:0] ST_SETUP   = 3'd2;
  localparam logic [2:0] ST_STROBE  = 3'd3;
  localparam logic [2:0] ST_HOLD    = 3'd4;

  function automatic logic win_is_open(input logic nhblank, input logic nvblank);
    return ~(nhblank & nvblank);
  endfunction

endpackage

// File: rtl/gvram_bus_master_blank_sync.sv
// Double-flop synchronizer for the host blanking signals plus the window-open decode.
module blank_sync
  import gvram_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic nhblank_i,
  input  logic nvblank_i,
  output logic win_open_o
);

  logic [1:0] nhb_q;
  logic [1:0] nvb_q;

  // Reset to "not blanking" so no memory cycle starts before real blanking is seen.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      nhb_q <= 2'b11;
      nvb_q <= 2'b11;
    end else begin
      nhb_q <= {nhb_q[0], nhblank_i};
      nvb_q <= {nvb_q[0], nvblank_i};
    end
  end

  assign win_open_o = win_is_open(nhb_q[1], nvb_q[1]);

endmodule

// File: rtl/gvram_bus_master.sv
// Host-side GVRAM bus initiator: turns a valid/ready command stream into I/O-port
// writes and blanking-confined memory cycles, aborting and replaying on window close.
module gvram_bus_master
  import gvram_pkg::*;
#(
  parameter int SETUP_CLKS  = 2,
  parameter int STROBE_CLKS = 6,
  parameter int HOLD_CLKS   = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_type,
  input  logic [13:0] cmd_addr,
  input  logic [7:0]  cmd_data,
  output logic        rsp_valid,
  output logic [7:0]  rsp_data,
  output logic [7:0]  abort_cnt,
  input  logic        nHBLANK,
  input  logic        nVBLANK,
  output logic        nCSED,
  output logic        nF47,
  output logic        nIWR,
  output logic        nRD,
  output logic        nWD,
  output logic [1:0]  IOAD,
  output logic [3:0]  IODB,
  output logic [13:0] AD,
  output logic [7:0]  DB_O,
  output logic        DB_OE,
  input  logic [7:0]  DB_I,
  output logic [2:0]  dbg_state
);

  // Handshakes: a command transfers on a CLK rise with cmd_valid && cmd_ready;
  // rsp_valid is a one-cycle pulse with no back-pressure, rsp_data holds until the next read.

  if (STROBE_CLKS < MIN_STROBE_CLKS || SETUP_CLKS < 1 || HOLD_CLKS < 1 ||
      SETUP_CLKS > 15 || STROBE_CLKS > 15 || HOLD_CLKS > 15) begin : g_param_check
    $error("gvram_bus_master: timing parameters out of range");
  end

  localparam logic [3:0] SETUP_LD  = 4'(SETUP_CLKS - 1);
  localparam logic [3:0] STROBE_LD = 4'(STROBE_CLKS - 1);
  localparam logic [3:0] HOLD_LD   = 4'(HOLD_CLKS - 1);

  logic        win_open;
  logic [2:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [1:0]  typ_q, typ_d;
  logic        cmd_ready_q, rsp_valid_q, db_oe_q;
  logic        ncsed_q, nf47_q, niwr_q, nrd_q, nwd_q;
  logic [7:0]  rsp_data_q, abort_cnt_q, db_o_q;
  logic [1:0]  ioad_q;
  logic [3:0]  iodb_q;
  logic [13:0] ad_q;
  logic        accept, mem_q, mem_d, abort, read_done, strobe_d, drive_d;

  blank_sync u_blank_sync (
    .clk_i      (CLK),
    .rst_ni     (nRST),
    .nhblank_i  (nHBLANK),
    .nvblank_i  (nVBLANK),
    .win_open_o (win_open)
  );

  assign accept    = (state_q == ST_IDLE) && cmd_ready_q && cmd_valid;
  assign typ_d     = accept ? cmd_type : typ_q;
  assign mem_q     = (typ_q == CMD_MWR) || (typ_q == CMD_MRD);
  assign mem_d     = (typ_d == CMD_MWR) || (typ_d == CMD_MRD);
  assign abort     = (state_q == ST_STROBE) && mem_q && !win_open;
  assign read_done = (state_q == ST_STROBE) && (state_d == ST_HOLD) && (typ_q == CMD_MRD);
  assign strobe_d  = (state_d == ST_STROBE);
  assign drive_d   = (state_d == ST_SETUP) || (state_d == ST_STROBE) || (state_d == ST_HOLD);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (cmd_type)
            CMD_IOW: begin
              state_d = ST_SETUP;
              cnt_d   = SETUP_LD;
            end
            CMD_MWR, CMD_MRD: begin
              state_d = win_open ? ST_SETUP : ST_WAITWIN;
              cnt_d   = SETUP_LD;
            end
            default: state_d = ST_IDLE;
          endcase
        end
      end
      ST_WAITWIN: begin
        if (win_open) begin
          state_d = ST_SETUP;
          cnt_d   = SETUP_LD;
        end
      end
      ST_SETUP: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_STROBE;
          cnt_d   = STROBE_LD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_STROBE: begin
        // Abort wins over completion, so a close in the last strobe cycle still replays.
        if (abort) begin
          state_d = ST_WAITWIN;
        end else if (cnt_q == 4'd0) begin
          state_d = ST_HOLD;
          cnt_d   = HOLD_LD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_HOLD: begin
        if (cnt_q == 4'd0) state_d = ST_IDLE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      typ_q       <= '0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      abort_cnt_q <= '0;
      ncsed_q     <= 1'b1;
      nf47_q      <= 1'b1;
      niwr_q      <= 1'b1;
      nrd_q       <= 1'b1;
      nwd_q       <= 1'b1;
      ioad_q      <= '0;
      iodb_q      <= '0;
      ad_q        <= '0;
      db_o_q      <= '0;
      db_oe_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      typ_q       <= typ_d;
      // A NOP keeps the FSM in IDLE but still costs one not-ready cycle.
      cmd_ready_q <= (state_d == ST_IDLE) && !accept;
      rsp_valid_q <= read_done;
      ncsed_q     <= !(strobe_d && mem_d);
      nf47_q      <= !(strobe_d && (typ_d == CMD_IOW));
      niwr_q      <= !(strobe_d && (typ_d == CMD_IOW));
      nrd_q       <= !(strobe_d && (typ_d == CMD_MRD));
      nwd_q       <= !(strobe_d && (typ_d == CMD_MWR));
      db_oe_q     <= drive_d && (typ_d == CMD_MWR);
      if (read_done) rsp_data_q <= DB_I;
      if (abort && (abort_cnt_q != 8'hFF)) abort_cnt_q <= abort_cnt_q + 8'd1;
      if (accept) begin
        case (cmd_type)
          CMD_IOW: begin
            ioad_q <= cmd_addr[1:0];
            iodb_q <= cmd_data[3:0];
          end
          CMD_MWR: begin
            ad_q   <= cmd_addr;
            db_o_q <= cmd_data;
          end
          CMD_MRD: ad_q <= cmd_addr;
          default: ;
        endcase
      end
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign abort_cnt = abort_cnt_q;
  assign nCSED     = ncsed_q;
  assign nF47      = nf47_q;
  assign nIWR      = niwr_q;
  assign nRD       = nrd_q;
  assign nWD       = nwd_q;
  assign IOAD      = ioad_q;
  assign IODB      = iodb_q;
  assign AD        = ad_q;
  assign DB_O      = db_o_q;
  assign DB_OE     = db_oe_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_gvram_bus_master.sv
// Directed bench for gvram_bus_master: per-cycle strobe timing checks plus a read-data
// scoreboard fed at issue time and drained by an independent response monitor.
module tb_gvram_bus_master;
  import gvram_pkg::*;

  logic        CLK, nRST;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_type;
  logic [13:0] cmd_addr;
  logic [7:0]  cmd_data;
  logic        rsp_valid;
  logic [7:0]  rsp_data, abort_cnt;
  logic        nHBLANK, nVBLANK;
  logic        nCSED, nF47, nIWR, nRD, nWD;
  logic [1:0]  IOAD;
  logic [3:0]  IODB;
  logic [13:0] AD;
  logic [7:0]  DB_O, DB_I;
  logic        DB_OE;
  logic [2:0]  dbg_state;
  logic [4:0]  strb;

  gvram_bus_master dut (
    .CLK(CLK), .nRST(nRST), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_type(cmd_type), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .abort_cnt(abort_cnt),
    .nHBLANK(nHBLANK), .nVBLANK(nVBLANK), .nCSED(nCSED), .nF47(nF47),
    .nIWR(nIWR), .nRD(nRD), .nWD(nWD), .IOAD(IOAD), .IODB(IODB), .AD(AD),
    .DB_O(DB_O), .DB_OE(DB_OE), .DB_I(DB_I), .dbg_state(dbg_state)
  );

  assign strb = {nCSED, nF47, nIWR, nRD, nWD};

  // ---------------- clock / reset ----------------
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int rsp_seen = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_d;

  int o_first, o_last, o_cnt, oe_first, oe_last, rv_cyc, rdy_cyc;
  logic [4:0]  o_mask;
  logic [13:0] cap_ad;
  logic [1:0]  cap_ioad;
  logic [3:0]  cap_iodb;
  logic [7:0]  cap_dbo;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge CLK) begin
    if (nRST && rsp_valid) begin
      rsp_seen++;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL rsp_unexpected: got data %0h, expected no response", rsp_data);
      end else begin
        exp_d = exp_q.pop_front();
        check("rsp_data", {24'h0, rsp_data}, {24'h0, exp_d});
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Returns at the sample point of cycle 1 (first cycle after the accept edge).
  task automatic issue(input logic [1:0] t, input logic [13:0] a, input logic [7:0] d);
    int guard;
    guard = 0;
    while (!cmd_ready && guard < 100) begin
      @(negedge CLK);
      guard++;
    end
    check("issue_ready", {31'h0, cmd_ready}, 32'h1);
    cmd_type  = t;
    cmd_addr  = a;
    cmd_data  = d;
    cmd_valid = 1'b1;
    @(negedge CLK);
    cmd_valid = 1'b0;
  endtask

  task automatic observe(input int start_c, input int budget);
    o_first = -1; o_last = -1; o_cnt = 0; o_mask = '0;
    oe_first = -1; oe_last = -1; rv_cyc = -1; rdy_cyc = -1;
    for (int c = start_c; c < start_c + budget; c++) begin
      if (strb != 5'b11111) begin
        if (o_first < 0) begin
          o_first  = c;
          cap_ad   = AD;
          cap_ioad = IOAD;
          cap_iodb = IODB;
          cap_dbo  = DB_O;
        end
        o_last = c;
        o_cnt++;
        o_mask |= ~strb;
      end
      if (DB_OE) begin
        if (oe_first < 0) oe_first = c;
        oe_last = c;
      end
      if (rsp_valid && rv_cyc < 0) rv_cyc = c;
      if (cmd_ready) begin
        rdy_cyc = c;
        break;
      end
      @(negedge CLK);
    end
  endtask

  // ---------------- stimulus ----------------
  int rs0, guard, lo_first, lo_last, lo_cnt;
  logic hi_ok;

  initial begin
    nRST = 1'b0; cmd_valid = 1'b0; cmd_type = '0; cmd_addr = '0; cmd_data = '0;
    nHBLANK = 1'b1; nVBLANK = 1'b1; DB_I = '0;
    repeat (3) @(negedge CLK);

    check("rst_strobes", {27'h0, strb}, 32'h1F);
    check("rst_ready", {31'h0, cmd_ready}, 32'h1);
    check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("rst_bus_outs", {4'h0, AD, IOAD, IODB, DB_O}, 32'h0);
    check("rst_misc_outs", {15'h0, DB_OE, abort_cnt, rsp_data}, 32'h0);
    check("rst_state", {29'h0, dbg_state}, {29'h0, ST_IDLE});
    nRST = 1'b1;
    @(negedge CLK);

    // I/O write with window closed: blanking is ignored
    issue(CMD_IOW, 14'h0002, 8'h0B);
    observe(1, 40);
    check("iow_strobe_first", o_first, 3);
    check("iow_strobe_last", o_last, 8);
    check("iow_strobe_mask", {27'h0, o_mask}, 32'b01100);
    check("iow_ioad", {30'h0, cap_ioad}, {30'h0, PORT_F6});
    check("iow_iodb", {28'h0, cap_iodb}, 32'hB);
    check("iow_ready_cycle", rdy_cyc, 11);

    // Memory write inside vertical blanking
    nVBLANK = 1'b0;
    repeat (3) @(negedge CLK);
    issue(CMD_MWR, 14'h1234, 8'hA5);
    observe(1, 40);
    check("mwr_strobe_first", o_first, 3);
    check("mwr_strobe_count", o_cnt, 6);
    check("mwr_strobe_mask", {27'h0, o_mask}, 32'b10001);
    check("mwr_oe_first", oe_first, 1);
    check("mwr_oe_last", oe_last, 10);
    check("mwr_ad", {18'h0, cap_ad}, 32'h1234);
    check("mwr_db_o", {24'h0, cap_dbo}, 32'hA5);
    check("mwr_ready_cycle", rdy_cyc, 11);

    // Memory read, window open
    DB_I = 8'h5A;
    exp_q.push_back(8'h5A);
    issue(CMD_MRD, 14'h0FFF, 8'h00);
    observe(1, 40);
    check("mrd_strobe_first", o_first, 3);
    check("mrd_strobe_last", o_last, 8);
    check("mrd_strobe_mask", {27'h0, o_mask}, 32'b10010);
    check("mrd_rsp_cycle", rv_cyc, 9);
    check("mrd_ad", {18'h0, cap_ad}, 32'h0FFF);
    check("mrd_ready_cycle", rdy_cyc, 11);
    DB_I = 8'h00;
    repeat (3) @(negedge CLK);
    check("mrd_rsp_data_hold", {24'h0, rsp_data}, 32'h5A);

    // Reserved command: one busy cycle, no bus activity
    issue(CMD_NOP, 14'h3FFF, 8'hFF);
    check("nop_busy", {31'h0, cmd_ready}, 32'h0);
    check("nop_strobes", {27'h0, strb}, 32'h1F);
    check("nop_ad_kept", {18'h0, AD}, 32'h0FFF);
    @(negedge CLK);
    check("nop_ready_again", {31'h0, cmd_ready}, 32'h1);

    // Memory write held in WAITWIN for 20 cycles, then window opens
    nVBLANK = 1'b1;
    repeat (3) @(negedge CLK);
    issue(CMD_MWR, 14'h0010, 8'h3C);
    hi_ok = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      if (strb != 5'b11111) hi_ok = 1'b0;
      if (c == 20) begin
        check("win_state_waitwin", {29'h0, dbg_state}, {29'h0, ST_WAITWIN});
        nVBLANK = 1'b0;
      end
      @(negedge CLK);
    end
    check("win_strobes_high", {31'h0, hi_ok}, 32'h1);
    observe(21, 60);
    check("win_strobe_first", o_first, 25);
    check("win_strobe_last", o_last, 30);
    check("win_ad", {18'h0, cap_ad}, 32'h0010);
    check("win_ready_cycle", rdy_cyc, 33);

    // Window closes in the third strobe cycle of a read: abort then replay
    rs0 = rsp_seen;
    DB_I = 8'hC3;
    exp_q.push_back(8'hC3);
    issue(CMD_MRD, 14'h0ABC, 8'h00);
    lo_first = -1; lo_last = -1; lo_cnt = 0;
    for (int c = 1; c <= 10; c++) begin
      if (strb != 5'b11111) begin
        if (lo_first < 0) lo_first = c;
        lo_last = c;
        lo_cnt++;
      end
      if (c == 3) nVBLANK = 1'b1;
      if (c == 6) begin
        check("abort_strobes_high", {27'h0, strb}, 32'h1F);
        check("abort_cnt_1", {24'h0, abort_cnt}, 32'h1);
        check("abort_state", {29'h0, dbg_state}, {29'h0, ST_WAITWIN});
      end
      if (c == 10) nVBLANK = 1'b0;
      @(negedge CLK);
    end
    check("abort_low_first", lo_first, 3);
    check("abort_low_last", lo_last, 5);
    observe(11, 60);
    check("replay_strobe_first", o_first, 15);
    check("replay_strobe_last", o_last, 20);
    check("replay_rsp_cycle", rv_cyc, 21);
    check("replay_ready_cycle", rdy_cyc, 23);
    check("replay_single_rsp", rsp_seen - rs0, 1);

    // Window closes in the last strobe cycle: sampled data discarded
    rs0 = rsp_seen;
    DB_I = 8'h77;
    exp_q.push_back(8'h78);
    issue(CMD_MRD, 14'h0ABD, 8'h00);
    lo_cnt = 0;
    for (int c = 1; c <= 10; c++) begin
      if (strb != 5'b11111) lo_cnt++;
      if (c == 6) nVBLANK = 1'b1;
      if (c == 9) begin
        check("late_abort_strobes_high", {27'h0, strb}, 32'h1F);
        check("late_abort_cnt_2", {24'h0, abort_cnt}, 32'h2);
        check("late_abort_rsp_data_kept", {24'h0, rsp_data}, 32'hC3);
        DB_I = 8'h78;
      end
      if (c == 10) nVBLANK = 1'b0;
      @(negedge CLK);
    end
    check("late_abort_low_count", lo_cnt, 6);
    observe(11, 60);
    check("late_replay_rsp_cycle", rv_cyc, 21);
    check("late_replay_single_rsp", rsp_seen - rs0, 1);

    // Asynchronous reset in the second strobe cycle of a read
    DB_I = 8'h11;
    exp_q.push_back(8'h11);
    issue(CMD_MRD, 14'h0055, 8'h00);
    repeat (3) @(negedge CLK);
    check("rstmid_strobe_active", {31'h0, nRD}, 32'h0);
    #2 nRST = 1'b0;
    #1;
    check("rstmid_strobes", {27'h0, strb}, 32'h1F);
    check("rstmid_ready", {31'h0, cmd_ready}, 32'h1);
    check("rstmid_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    exp_q.delete();
    rs0 = rsp_seen;
    @(negedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
    repeat (15) @(negedge CLK);
    check("rstmid_no_rsp", rsp_seen - rs0, 0);
    check("rstmid_abort_cnt_clr", {24'h0, abort_cnt}, 32'h0);
    check("rstmid_state_idle", {29'h0, dbg_state}, {29'h0, ST_IDLE});

    // 300 forced aborts: counter saturates at 255
    issue(CMD_MWR, 14'h0100, 8'h99);
    for (int i = 0; i < 300; i++) begin
      guard = 0;
      while (nCSED && guard < 50) begin
        @(negedge CLK);
        guard++;
      end
      if (nCSED) begin
        check("sat_strobe_timeout", {31'h0, nCSED}, 32'h0);
        break;
      end
      nVBLANK = 1'b1;
      guard = 0;
      while (dbg_state != ST_WAITWIN && guard < 50) begin
        @(negedge CLK);
        guard++;
      end
      if (dbg_state != ST_WAITWIN) begin
        check("sat_waitwin_timeout", {29'h0, dbg_state}, {29'h0, ST_WAITWIN});
        break;
      end
      nVBLANK = 1'b0;
      if (i == 253) check("abort_cnt_254", {24'h0, abort_cnt}, 32'd254);
      if (i == 254) check("abort_cnt_255", {24'h0, abort_cnt}, 32'd255);
    end
    check("abort_cnt_saturated", {24'h0, abort_cnt}, 32'd255);
    guard = 0;
    while (!cmd_ready && guard < 100) begin
      @(negedge CLK);
      guard++;
    end
    check("sat_final_ready", {31'h0, cmd_ready}, 32'h1);

    repeat (3) @(negedge CLK);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
